// File: rtl/mdu_ctrl_if.sv
// Request/response bundle between the EX stage and the multiply/divide controller.
interface mdu_ctrl_if #(
  parameter int unsigned W = 32
);
  logic         start;
  logic [5:0]   funct;
  logic [W-1:0] rs_val;
  logic [W-1:0] rt_val;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         done;
  logic         div_zero;

  modport master (
    output start, funct, rs_val, rt_val,
    input  busy, hi, lo, done, div_zero
  );

  modport slave (
    input  start, funct, rs_val, rt_val,
    output busy, hi, lo, done, div_zero
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide controller owning HI/LO; fixed 34-cycle stall for mult/div.
// Optional divider datapath is enabled by defining MDU_DIV_EN.
module mdu_ctrl (
  input  logic        clk,
  input  logic        rst,
  mdu_ctrl_if.slave   bus
);
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

`ifdef MDU_DIV_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_FIN = 2'd2, S_DIV = 2'd3} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_FIN = 2'd2} state_e;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d;       // multiplicand or divisor magnitude
  logic [2*W-1:0]  acc_q, acc_d;   // {upper, lower}: product, or {remainder, quotient}
  logic            neg_lo_q, neg_lo_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            done_q, done_d;
`ifdef MDU_DIV_EN
  logic            neg_hi_q, neg_hi_d;
  logic            op_div_q, op_div_d;
  logic            dz_q, dz_d;
`endif

  logic            is_mul, is_div, signed_op, rs_neg, rt_neg, busy_c;
  logic [W-1:0]    rs_mag, rt_mag;
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  prod_fix;

  // Instruction decode and operand magnitude capture
  assign is_mul    = bus.start & ((bus.funct == F_MULT) | (bus.funct == F_MULTU));
  assign is_div    = bus.start & ((bus.funct == F_DIV)  | (bus.funct == F_DIVU));
  assign signed_op = ~bus.funct[0];
  assign rs_neg    = signed_op & bus.rs_val[W-1];
  assign rt_neg    = signed_op & bus.rt_val[W-1];
  assign rs_mag    = rs_neg ? (~bus.rs_val + W'(1)) : bus.rs_val;
  assign rt_mag    = rt_neg ? (~bus.rt_val + W'(1)) : bus.rt_val;

  assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign prod_fix  = neg_lo_q ? (~acc_q + (2*W)'(1)) : acc_q;

`ifdef MDU_DIV_EN
  logic            rt_zero;
  logic [W:0]      div_shift, div_diff;
  logic [W-1:0]    quot_fix, rem_fix;

  assign rt_zero   = (bus.rt_val == '0);
  assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff  = div_shift - {1'b0, a_q};
  assign quot_fix  = neg_lo_q ? (~acc_q[W-1:0] + W'(1)) : acc_q[W-1:0];
  assign rem_fix   = neg_hi_q ? (~acc_q[2*W-1:W] + W'(1)) : acc_q[2*W-1:W];
  assign busy_c    = (state_q != S_IDLE) | is_mul | (is_div & ~rt_zero);
`else
  assign busy_c    = (state_q != S_IDLE) | is_mul;
`endif

  // Next-state, datapath step and HI/LO update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    acc_d    = acc_q;
    neg_lo_d = neg_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MDU_DIV_EN
    neg_hi_d = neg_hi_q;
    op_div_d = op_div_q;
    dz_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (is_mul) begin
          state_d  = S_MUL;
          cnt_d    = '0;
          a_d      = rs_mag;
          acc_d    = {{W{1'b0}}, rt_mag};
          neg_lo_d = rs_neg ^ rt_neg;
`ifdef MDU_DIV_EN
          op_div_d = 1'b0;
`endif
        end else if (is_div) begin
`ifdef MDU_DIV_EN
          if (rt_zero) begin
            done_d = 1'b1;
            dz_d   = 1'b1;
          end else begin
            state_d  = S_DIV;
            cnt_d    = '0;
            a_d      = rt_mag;
            acc_d    = {{W{1'b0}}, rs_mag};
            neg_lo_d = rs_neg ^ rt_neg;
            neg_hi_d = rs_neg;
            op_div_d = 1'b1;
          end
`else
          done_d = 1'b1;
`endif
        end else if (bus.start && bus.funct == F_MTHI) begin
          hi_d = bus.rs_val;
        end else if (bus.start && bus.funct == F_MTLO) begin
          lo_d = bus.rs_val;
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[W-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == {CW{1'b1}}) state_d = S_FIN;
      end
`ifdef MDU_DIV_EN
      S_DIV: begin
        // Restoring step: keep the trial difference only when it did not borrow
        if (!div_diff[W]) acc_d = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
        else              acc_d = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == {CW{1'b1}}) state_d = S_FIN;
      end
`endif
      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
`ifdef MDU_DIV_EN
        if (op_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end
`else
        hi_d = prod_fix[2*W-1:W];
        lo_d = prod_fix[W-1:0];
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      acc_q    <= '0;
      neg_lo_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifdef MDU_DIV_EN
      neg_hi_q <= 1'b0;
      op_div_q <= 1'b0;
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      acc_q    <= acc_d;
      neg_lo_q <= neg_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef MDU_DIV_EN
      neg_hi_q <= neg_hi_d;
      op_div_q <= op_div_d;
      dz_q     <= dz_d;
`endif
    end
  end

  assign bus.busy = busy_c;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.done = done_q;
`ifdef MDU_DIV_EN
  assign bus.div_zero = dz_q;
`else
  assign bus.div_zero = 1'b0;
`endif
endmodule
